isu_fetch: RTL
==============

// Module: isu_fetch
// PURPOSE
//  Instruction fetch sequencer that reads the clocked instruction ROM (isu_mem).
//  Drives the word address, absorbs the ROM's 1-cycle read latency, and buffers
//  returned words in a 2-entry FIFO. Presents {instr, pc} to decode on a
//  valid/ready handshake. Accepts redirect (branch/jump) requests that flush
//  all fetched state.
// PARAMETERS
//  A_WIDTH   8   word-address width; must match the ROM's A_WIDTH
//  D_WIDTH   32  instruction width; must match the ROM's D_WIDTH
//  RESET_PC  0   fetch address loaded at reset (A_WIDTH bits)
// PORTS
//  clk             in   1        clock, rising edge
//  rst_n           in   1        async reset, active low
//  mem_addr        out  A_WIDTH  ROM address (= pc_q, direct from register)
//  mem_rdata       in   D_WIDTH  ROM data; holds mem[addr sampled at previous edge]
//  redirect_valid  in   1        1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   A_WIDTH  new fetch address
//  out_valid       out  1        FIFO head valid
//  out_ready       in   1        decode accepts head this cycle
//  out_instr       out  D_WIDTH  head instruction word
//  out_pc          out  A_WIDTH  address the head word was fetched from
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - pc_q = RESET_PC; inflight = 0; FIFO count = 0.
//    - out_valid = 0; out_instr = 0; out_pc = 0. Outputs clear immediately,
//      without waiting for clk.
//  - ROM samples mem_addr every edge. A word is used only if that edge was an
//    "issue".
//  - pop   = out_valid & out_ready.
//  - issue = !redirect_valid & (count + inflight - pop < 2).
//  - On an issue edge:
//    - inflight <= 1; inflight_pc <= pc_q.
//    - pc_q <= pc_q + 1, modulo 2^A_WIDTH (8'hFF -> 8'h00; no flag).
//  - On a non-issue edge, inflight <= 0 and pc_q holds.
//  - Edge after an issue: {mem_rdata, inflight_pc} pushed into the FIFO.
//    - The free slot is guaranteed by the issue rule; overflow is impossible.
//  - Push and pop on the same edge: count unchanged, order preserved.
//  - Latency:
//    - issue at edge N -> word in FIFO after edge N+1.
//    - First out_valid after reset: after the 2nd rising edge following rst_n
//      release.
//  - Throughput: 1 word/cycle sustained while out_ready = 1.
//  - Backpressure: while out_valid & !out_ready, out_instr and out_pc are
//    stable. No word is dropped or duplicated.
//  - Redirect (highest priority) at edge N:
//    - FIFO flushed (count = 0, out_valid = 0 after edge N).
//    - inflight cleared, so the word arriving at N+1 is discarded.
//    - pc_q <= redirect_pc. No issue at edge N.
//    - Issue at N+1; out_valid = 1 with out_pc = redirect_pc after N+2.
//  - Redirect and pop on the same edge: the pop counts as consumed; the flush
//    still clears everything else.
//  - Back-to-back redirects: the last one wins. No stale word ever reaches out.
//  - Reset mid-operation discards all state. Fetch restarts at RESET_PC.
// TESTING
//  1. mem[i] = 32'h100+i, out_ready = 1, release rst_n
//     -> out_valid rises at 2nd edge; pc 0,1,2,... with instr 0x100,0x101,...
//        on consecutive cycles.
//  2. Stream, then out_ready = 0 for 5 cycles
//     -> head stable; count saturates at 2.
//     Release -> next pcs contiguous; no gap or duplicate.
//  3. FIFO full, word inflight, redirect_pc = 8'h40
//     -> out_valid = 0 for 2 cycles, then pc 0x40, 0x41 ...
//        No pre-redirect word appears.
//  4. redirect_pc = 8'hFE with out_ready = 1
//     -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
//  5. rst_n low mid-stream, between edges
//     -> out_valid = 0 immediately.
//     After release -> restart at RESET_PC with the latency of scenario 1.
//  6. redirect_valid and pop in the same cycle, then two consecutive redirects
//     (0x10, 0x20)
//     -> first word after the redirects is pc 0x20; 0x10 never appears.

Source files
------------

// File: rtl/isu_fetch.sv
// Instruction fetch sequencer for the clocked ROM: issues word addresses, absorbs the
// 1-cycle read latency and buffers returned words in a 2-entry FIFO toward decode.
module isu_fetch #(
  parameter int                   A_WIDTH  = 8,
  parameter int                   D_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [A_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0] out_pc
);

  localparam logic [A_WIDTH-1:0] PC_ONE = A_WIDTH'(1);

  logic [A_WIDTH-1:0] pc_q;
  logic               inflight;
  logic [A_WIDTH-1:0] inflight_pc;

  logic [D_WIDTH-1:0] fifo_instr [2];
  logic [A_WIDTH-1:0] fifo_pc    [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;

  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occupancy;

  // Handshake: a word transfers on every rising edge where out_valid & out_ready;
  // the head holds its instr/pc while out_valid & !out_ready.
  assign out_valid = (count != 2'd0);
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];
  assign mem_addr  = pc_q;

  assign pop  = out_valid & out_ready;
  assign push = inflight & ~redirect_valid;

  // Occupancy counts the word still in the ROM pipe, so a free slot always
  // exists when it lands; pop never exceeds count so this cannot underflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = ~redirect_valid & (occupancy < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight      <= 1'b0;
      inflight_pc   <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      fifo_instr[0] <= '0;
      fifo_instr[1] <= '0;
      fifo_pc[0]    <= '0;
      fifo_pc[1]    <= '0;
    end else if (redirect_valid) begin
      // Flush everything, including the word returning next cycle.
      pc_q     <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + PC_ONE;
      end
      if (push) begin
        fifo_instr[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]    <= inflight_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
